snake_body_engine: RTL and testbench

Parametrised snake movement and body-storage engine. It replaces the fixed single-segment head/body coordinate pair with a ring of up to MAX_LENGTH segments. It supports selectable wall/wrap mode, serial self-collision scanning and a registered per-block lookup port for the graphic path. It sits between the game FSM (which supplies game_tik, direction and grow) and the graphic renderer (which issues block-coordinate queries every pixel).

---
 rtl/snake_body_engine.sv | 176 +++++++++++++++++
 tb/tb_snake_body_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_body_engine.sv
// rtl/snake_body_engine.sv - ring-buffer snake body with step FSM, serial self-collision scan and per-block query
module snake_body_engine #(
    parameter int COORD_BIT   = 7,
    parameter int GRID_W      = 80,
    parameter int GRID_H      = 60,
    parameter int MAX_LENGTH  = 16,
    parameter int INIT_LENGTH = 3,
    parameter int INIT_X      = 10,
    parameter int INIT_Y      = 10,
    parameter int WRAP_MODE   = 0,
    parameter int LEN_BIT     = $clog2(MAX_LENGTH + 1)
) (
    input  logic                 clock_25,
    input  logic                 reset,
    input  logic                 game_tik,
    input  logic [1:0]           direction,
    input  logic                 grow,
    input  logic [COORD_BIT-1:0] query_x,
    input  logic [COORD_BIT-1:0] query_y,
    output logic                 query_hit,
    output logic                 query_head,
    output logic [COORD_BIT-1:0] snake_head_x,
    output logic [COORD_BIT-1:0] snake_head_y,
    output logic [LEN_BIT-1:0]   snake_length,
    output logic                 busy,
    output logic                 step_done,
    output logic                 collision_detected
);

    localparam int PTR_BIT = $clog2(MAX_LENGTH);
    localparam int SUM_BIT = PTR_BIT + LEN_BIT + 1;
    localparam logic [COORD_BIT-1:0] X_MAX   = COORD_BIT'(GRID_W - 1);
    localparam logic [COORD_BIT-1:0] Y_MAX   = COORD_BIT'(GRID_H - 1);
    localparam logic [LEN_BIT-1:0]   MAX_LEN = LEN_BIT'(MAX_LENGTH);

    typedef enum logic [2:0] {S_IDLE, S_MOVE, S_SCAN, S_DONE, S_DEAD} state_t;

    state_t               state;
    logic [COORD_BIT-1:0] seg_x [MAX_LENGTH];
    logic [COORD_BIT-1:0] seg_y [MAX_LENGTH];
    logic [PTR_BIT-1:0]   head_ptr;
    logic [PTR_BIT-1:0]   new_ptr;
    logic [PTR_BIT-1:0]   scan_slot;
    logic [LEN_BIT-1:0]   scan_idx;
    logic [1:0]           cur_dir;
    logic                 grow_q;
    logic                 is_opposite;
    logic [COORD_BIT-1:0] next_x;
    logic [COORD_BIT-1:0] next_y;
    logic                 wall;
    logic                 q_hit;
    logic                 q_head;

    // Physical slot of logical segment `off`, counted from the head slot.
    function automatic logic [PTR_BIT-1:0] slot_of(input logic [PTR_BIT-1:0] base,
                                                   input logic [LEN_BIT-1:0] off);
        logic [SUM_BIT-1:0] sum;
        sum = SUM_BIT'(base) + SUM_BIT'(off);
        if (sum >= SUM_BIT'(MAX_LENGTH))
            sum = sum - SUM_BIT'(MAX_LENGTH);
        return sum[PTR_BIT-1:0];
    endfunction

    assign is_opposite = (direction[1] == cur_dir[1]) && (direction[0] != cur_dir[0]);
    assign new_ptr     = (head_ptr == '0) ? PTR_BIT'(MAX_LENGTH - 1) : head_ptr - 1'b1;
    assign scan_slot   = slot_of(head_ptr, scan_idx);

    always_comb begin
        next_x = snake_head_x;
        next_y = snake_head_y;
        wall   = 1'b0;
        case (cur_dir)
            2'b00: if (snake_head_x == X_MAX) begin
                       if (WRAP_MODE != 0) next_x = '0;
                       else                wall   = 1'b1;
                   end else next_x = snake_head_x + 1'b1;
            2'b01: if (snake_head_x == '0) begin
                       if (WRAP_MODE != 0) next_x = X_MAX;
                       else                wall   = 1'b1;
                   end else next_x = snake_head_x - 1'b1;
            2'b10: if (snake_head_y == '0) begin
                       if (WRAP_MODE != 0) next_y = Y_MAX;
                       else                wall   = 1'b1;
                   end else next_y = snake_head_y - 1'b1;
            default: if (snake_head_y == Y_MAX) begin
                       if (WRAP_MODE != 0) next_y = '0;
                       else                wall   = 1'b1;
                   end else next_y = snake_head_y + 1'b1;
        endcase
    end

    // Each physical slot knows its logical index from the head pointer; only live segments count.
    always_comb begin
        int off;
        q_hit  = 1'b0;
        q_head = 1'b0;
        off    = 0;
        for (int j = 0; j < MAX_LENGTH; j++) begin
            off = j - int'(head_ptr);
            if (off < 0)
                off = off + MAX_LENGTH;
            if (off < int'(snake_length) && seg_x[j] == query_x && seg_y[j] == query_y) begin
                q_hit = 1'b1;
                if (off == 0)
                    q_head = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (!reset) begin
            state              <= S_IDLE;
            head_ptr           <= '0;
            scan_idx           <= '0;
            cur_dir            <= 2'b00;
            grow_q             <= 1'b0;
            snake_head_x       <= COORD_BIT'(INIT_X);
            snake_head_y       <= COORD_BIT'(INIT_Y);
            snake_length       <= LEN_BIT'(INIT_LENGTH);
            busy               <= 1'b0;
            step_done          <= 1'b0;
            collision_detected <= 1'b0;
            query_hit          <= 1'b0;
            query_head         <= 1'b0;
            for (int i = 0; i < MAX_LENGTH; i++) begin
                seg_x[i] <= (i < INIT_LENGTH) ? COORD_BIT'(INIT_X - i) : '0;
                seg_y[i] <= (i < INIT_LENGTH) ? COORD_BIT'(INIT_Y) : '0;
            end
        end else begin
            query_hit  <= q_hit;
            query_head <= q_head;
            step_done  <= 1'b0;
            case (state)
                S_IDLE: if (game_tik) begin
                    if (!is_opposite)
                        cur_dir <= direction;
                    grow_q <= grow;
                    busy   <= 1'b1;
                    state  <= S_MOVE;
                end
                S_MOVE: if (wall) begin
                    collision_detected <= 1'b1;
                    busy               <= 1'b0;
                    state              <= S_DEAD;
                end else begin
                    head_ptr        <= new_ptr;
                    seg_x[new_ptr]  <= next_x;
                    seg_y[new_ptr]  <= next_y;
                    snake_head_x    <= next_x;
                    snake_head_y    <= next_y;
                    if (grow_q && snake_length < MAX_LEN)
                        snake_length <= snake_length + 1'b1;
                    scan_idx <= LEN_BIT'(1);
                    state    <= S_SCAN;
                end
                S_SCAN: if (seg_x[scan_slot] == snake_head_x && seg_y[scan_slot] == snake_head_y) begin
                    collision_detected <= 1'b1;
                    busy               <= 1'b0;
                    state              <= S_DEAD;
                end else if (scan_idx == snake_length - 1'b1) begin
                    step_done <= 1'b1;
                    state     <= S_DONE;
                end else begin
                    scan_idx <= scan_idx + 1'b1;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_DEAD: collision_detected <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// tb/tb_snake_body_engine.sv - wall and wrap instances driven together, checked against a list-based snake model
module tb_snake_body_engine;

    localparam int MAXL = 16;
    localparam int GW   = 80;
    localparam int GH   = 60;
    localparam int LB   = $clog2(MAXL + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       game_tik = 1'b0;
    logic       grow = 1'b0;
    logic [1:0] direction = 2'b00;
    logic [6:0] qx = '0;
    logic [6:0] qy = '0;

    logic          q_hit [2];
    logic          q_head [2];
    logic          busy [2];
    logic          sdone [2];
    logic          coll [2];
    logic [6:0]    hx [2];
    logic [6:0]    hy [2];
    logic [LB-1:0] len [2];

    int total = 0;
    int bad   = 0;

    always #20 clk = ~clk;

    snake_body_engine #(.WRAP_MODE(0)) u_wall (
        .clock_25(clk), .reset(rst_n), .game_tik(game_tik), .direction(direction), .grow(grow),
        .query_x(qx), .query_y(qy), .query_hit(q_hit[0]), .query_head(q_head[0]),
        .snake_head_x(hx[0]), .snake_head_y(hy[0]), .snake_length(len[0]),
        .busy(busy[0]), .step_done(sdone[0]), .collision_detected(coll[0]));

    snake_body_engine #(.WRAP_MODE(1)) u_wrap (
        .clock_25(clk), .reset(rst_n), .game_tik(game_tik), .direction(direction), .grow(grow),
        .query_x(qx), .query_y(qy), .query_hit(q_hit[1]), .query_head(q_head[1]),
        .snake_head_x(hx[1]), .snake_head_y(hy[1]), .snake_length(len[1]),
        .busy(busy[1]), .step_done(sdone[1]), .collision_detected(coll[1]));

    int   cyc = 0;
    int   done_cyc [2] = '{-1, -1};
    int   done_cnt [2] = '{0, 0};
    int   coll_cyc [2] = '{-1, -1};
    logic coll_prev [2] = '{1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle numbers: the period following edge m is cycle m+1.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sdone[k] === 1'b1) begin
                done_cyc[k] <= cyc + 1;
                done_cnt[k] <= done_cnt[k] + 1;
            end
            if (coll[k] === 1'b1 && coll_prev[k] !== 1'b1)
                coll_cyc[k] <= cyc + 1;
            coll_prev[k] <= coll[k];
        end
    end

    // Model: segment list, index 0 = head. Instance 0 = wall mode, 1 = wrap mode.
    int mx [2][MAXL];
    int my [2][MAXL];
    int mlen [2];
    int mdir [2];
    bit mdead [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mlen[k] = 3; mdir[k] = 0; mdead[k] = 0;
            for (int i = 0; i < MAXL; i++) begin
                mx[k][i] = 10 - i; my[k][i] = 10;
            end
        end
    endtask

    function automatic int dxof(input int d);
        return (d == 0) ? 1 : (d == 1) ? -1 : 0;
    endfunction
    function automatic int dyof(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    // kind: 0 completed, 1 wall death, 2 self death at index `at`, 3 already dead
    task automatic model_step(input int k, input int d, input bit g, output int kind, output int at);
        int nx, ny;
        kind = 0; at = 0;
        if (mdead[k]) begin kind = 3; return; end
        if (!(d != mdir[k] && dxof(d) + dxof(mdir[k]) == 0 && dyof(d) + dyof(mdir[k]) == 0))
            mdir[k] = d;
        nx = mx[k][0] + dxof(mdir[k]);
        ny = my[k][0] + dyof(mdir[k]);
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            if (k == 0) begin mdead[k] = 1; kind = 1; return; end
            nx = (nx + GW) % GW;
            ny = (ny + GH) % GH;
        end
        for (int i = MAXL - 1; i > 0; i--) begin
            mx[k][i] = mx[k][i-1]; my[k][i] = my[k][i-1];
        end
        mx[k][0] = nx; my[k][0] = ny;
        if (g && mlen[k] < MAXL) mlen[k]++;
        for (int i = 1; i < mlen[k]; i++) begin
            if (mx[k][i] == nx && my[k][i] == ny) begin
                mdead[k] = 1; kind = 2; at = i; return;
            end
        end
    endtask

    function automatic bit model_hit(input int k, input int x, input int y);
        for (int i = 0; i < mlen[k]; i++)
            if (mx[k][i] == x && my[k][i] == y) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk({tag, "_hx"}, hx[k], 10);
            chk({tag, "_hy"}, hy[k], 10);
            chk({tag, "_len"}, len[k], 3);
            chk({tag, "_busy"}, busy[k], 0);
            chk({tag, "_done"}, sdone[k], 0);
            chk({tag, "_coll"}, coll[k], 0);
            chk({tag, "_qhit"}, q_hit[k], 0);
            chk({tag, "_qhead"}, q_head[k], 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0; game_tik = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic q_expect(input int x, input int y, input bit ehit, input bit ehead);
        @(negedge clk); qx = 7'(x); qy = 7'(y);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("q_dir_hit", q_hit[k], ehit);
            chk("q_dir_head", q_head[k], ehead);
        end
    endtask

    // Back-to-back queries: each negedge checks the previous query and presents the next.
    task automatic qburst(input int n);
        int x, y, i;
        bit ph [2];
        bit pd [2];
        for (int s = 0; s <= n; s++) begin
            @(negedge clk);
            if (s > 0)
                for (int k = 0; k < 2; k++) begin
                    chk("q_rand_hit", q_hit[k], ph[k]);
                    chk("q_rand_head", q_head[k], pd[k]);
                end
            if (s < n) begin
                if ($urandom_range(0, 2) == 0) begin
                    x = int'($urandom_range(0, GW - 1)); y = int'($urandom_range(0, GH - 1));
                end else begin
                    i = int'($urandom_range(0, mlen[0] - 1));
                    x = mx[0][i] + int'($urandom_range(0, 2)) - 1;
                    y = my[0][i] + int'($urandom_range(0, 2)) - 1;
                    if (x < 0) x = 0; if (x >= GW) x = GW - 1;
                    if (y < 0) y = 0; if (y >= GH) y = GH - 1;
                end
                qx = 7'(x); qy = 7'(y);
                for (int k = 0; k < 2; k++) begin
                    ph[k] = model_hit(k, x, y);
                    pd[k] = (mx[k][0] == x && my[k][0] == y);
                end
            end
        end
    endtask

    task automatic do_step(input int d, input bit g, input bit extra);
        int kind [2];
        int at [2];
        int pre [2];
        int t;
        @(negedge clk);
        t = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            pre[k] = done_cnt[k];
            model_step(k, d, g, kind[k], at[k]);
        end
        game_tik = 1'b1; direction = 2'(d); grow = g;
        @(negedge clk);
        game_tik = 1'b0;
        for (int k = 0; k < 2; k++)
            if (kind[k] != 3) chk("busy_in_move", busy[k], 1);
        if (extra) begin
            game_tik = 1'b1;
            @(negedge clk);
            game_tik = 1'b0;
        end
        repeat (MAXL + 6) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("head_x", hx[k], mx[k][0]);
            chk("head_y", hy[k], my[k][0]);
            chk("length", len[k], mlen[k]);
            chk("collision", coll[k], mdead[k]);
            chk("busy_idle", busy[k], 0);
            chk("done_pulses", done_cnt[k] - pre[k], (kind[k] == 0) ? 1 : 0);
            if (kind[k] == 0) chk("done_cycle", done_cyc[k], t + mlen[k] + 1);
            if (kind[k] == 1) chk("wall_cycle", coll_cyc[k], t + 2);
            if (kind[k] == 2) chk("self_cycle", coll_cyc[k], t + 2 + at[k]);
        end
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        q_expect(10, 10, 1, 1);
        q_expect(9, 10, 1, 0);
        q_expect(0, 0, 0, 0);
        q_expect(8, 10, 1, 0);

        do_step(0, 0, 0);
        q_expect(8, 10, 0, 0);
        q_expect(11, 10, 1, 1);

        do_step(1, 0, 1);
        chk("opposite_ignored_x", hx[0], 12);

        for (int i = 0; i < 14; i++) do_step(0, 1, 0);
        chk("length_capped", len[0], MAXL);
        qburst(6);

        while (mx[0][0] < GW - 1) begin
            do_step(0, 1'($urandom_range(0, 1)), 0);
            if (mx[0][0] % 10 == 0) qburst(3);
        end
        do_step(0, 0, 0);
        chk("wall_head_stays", hx[0], GW - 1);
        chk("wrap_head_zero", hx[1], 0);
        do_step(2, 0, 0);
        qburst(6);

        // Reset landing in the middle of a step
        @(negedge clk); game_tik = 1'b1; direction = 2'b11; grow = 1'b0;
        @(negedge clk); game_tik = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        model_reset();

        do_step(0, 1, 0);
        do_step(0, 1, 0);
        do_step(0, 0, 0);
        do_step(3, 0, 0);
        do_step(1, 0, 0);
        do_step(2, 0, 0);
        chk("square_collision", coll[0], 1);
        do_step(0, 0, 1);
        qburst(4);

        do_reset();
        for (int s = 0; s < 60; s++) begin
            if (mdead[0] && mdead[1]) do_reset();
            do_step(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            qburst(4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
